// File: rtl/switch_box_config_loader.sv
// Streams header + payload words into a chain of switch boxes: one one-hot
// config strobe per payload word, with the word broadcast on sb_config_data.
module switch_box_config_loader #(
    parameter int NUM_BOXES = 16,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_in_valid,
    output logic                 cfg_in_ready,
    input  logic [31:0]          cfg_in_data,
    output logic [NUM_BOXES-1:0] sb_config_en,
    output logic [31:0]          sb_config_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ERR  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [16:0] LIMIT = 17'(NUM_BOXES);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [15:0]            rem_q, rem_d;
    logic [NUM_BOXES-1:0]   en_q, en_d;
    logic [NUM_BOXES-1:0]   idx_onehot;
    logic [31:0]            data_q, data_d;
    logic                   err_q, err_d;
    logic                   accept;
    logic [15:0]            hdr_start, hdr_count;
    logic [16:0]            hdr_end;

    // Ready is a pure function of state so it never loops back through valid.
    assign cfg_in_ready = (state_q != DONE);
    assign accept       = cfg_in_valid && cfg_in_ready;

    assign hdr_start = cfg_in_data[15:0];
    assign hdr_count = cfg_in_data[31:16];
    assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};

    generate
        for (genvar gi = 0; gi < NUM_BOXES; gi++) begin : g_onehot
            assign idx_onehot[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        en_d    = '0;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hdr_count == 16'd0) begin
                        state_d = DONE;
                    end else if (hdr_end > LIMIT) begin
                        state_d = ERR;
                        rem_d   = hdr_count;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                        idx_d   = hdr_start[IDX_W-1:0];
                        rem_d   = hdr_count;
                        err_d   = 1'b0;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    en_d   = idx_onehot;
                    data_d = cfg_in_data;
                    idx_d  = idx_q + 1'b1;
                    rem_d  = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = DONE;
                    end
                end
            end
            ERR: begin
                // Out-of-range transfer: swallow the payload without strobing.
                if (accept) begin
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            en_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            en_q    <= en_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign sb_config_en   = en_q;
    assign sb_config_data = data_q;
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign err            = err_q;

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Scoreboard bench: directed transfers push expected strobes/done events,
// a negedge monitor pops and compares whatever the loader presents.
module tb_switch_box_config_loader;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_in_valid = 1'b0;
    logic          cfg_in_ready;
    logic [31:0]   cfg_in_data = '0;
    logic [N-1:0]  sb_config_en;
    logic [31:0]   sb_config_data;
    logic          busy, done, err;

    switch_box_config_loader #(.NUM_BOXES(N), .IDX_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_in_valid   (cfg_in_valid),
        .cfg_in_ready   (cfg_in_ready),
        .cfg_in_data    (cfg_in_data),
        .sb_config_en   (sb_config_en),
        .sb_config_data (sb_config_data),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] en;
        logic [31:0]  data;
    } exp_t;

    exp_t        exp_q[$];
    logic        exp_done_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_data = '0;
    logic [31:0] box_model [N];
    logic [31:0] sent [N];

    function automatic logic [31:0] hdr(input int start, input int count);
        logic [15:0] s;
        logic [15:0] c;
        s = 16'(start);
        c = 16'(count);
        return {c, s};
    endfunction

    task automatic expect_strobe(input int box, input logic [31:0] d);
        exp_t e;
        e.en   = N'(1) << box;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Drive one word, hold until accepted, then optionally idle for gap cycles.
    task automatic send(input logic [31:0] d, input int gap);
        int waited;
        cfg_in_valid = 1'b1;
        cfg_in_data  = d;
        waited = 0;
        while (!cfg_in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cfg_in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready stuck at 0 for %0d cycles, expected 1", waited);
        end
        @(posedge clk); #1;
        $display("sent word 0x%08h", d);
        if (gap > 0) begin
            cfg_in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int cycles);
        cfg_in_valid = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic  de;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ready_vs_done", {31'd0, cfg_in_ready}, {31'd0, !done});
                if (sb_config_en != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: en=0x%04h data=0x%08h, expected no strobe",
                                 sb_config_en, sb_config_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_en", 32'(sb_config_en), 32'(e.en));
                        check("strobe_data", sb_config_data, e.data);
                        $display("strobe en=0x%04h data=0x%08h", sb_config_en, sb_config_data);
                        last_data = e.data;
                    end
                    for (int i = 0; i < N; i++) begin
                        if (sb_config_en[i]) box_model[i] = sb_config_data;
                    end
                end else begin
                    check("data_hold", sb_config_data, last_data);
                end
                if (done) begin
                    if (exp_done_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: done=1, expected 0");
                    end else begin
                        de = exp_done_q.pop_front();
                        check("done_err", {31'd0, err}, {31'd0, de});
                        check("done_busy", {31'd0, busy}, 32'd1);
                        $display("done err=%0b", err);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < N; i++) begin
            box_model[i] = '0;
            sent[i]      = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_en", 32'(sb_config_en), 32'd0);
        check("rst_data", sb_config_data, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", {31'd0, cfg_in_ready}, 32'd1);

        // 1: three back-to-back words to boxes 2..4
        expect_strobe(2, 32'hAAAA_0001);
        expect_strobe(3, 32'hBBBB_0002);
        expect_strobe(4, 32'hCCCC_0003);
        exp_done_q.push_back(1'b0);
        send(hdr(2, 3), 0);
        send(32'hAAAA_0001, 0);
        send(32'hBBBB_0002, 0);
        send(32'hCCCC_0003, 0);
        idle(3);

        // 2: last box in range, then one past the end
        expect_strobe(15, 32'hDEAD_BEEF);
        exp_done_q.push_back(1'b0);
        send(hdr(15, 1), 0);
        send(32'hDEAD_BEEF, 0);
        idle(3);
        check("err_after_ok", {31'd0, err}, 32'd0);
        exp_done_q.push_back(1'b1);
        send(hdr(15, 2), 0);
        send(32'h1111_1111, 0);
        send(32'h2222_2222, 0);
        idle(3);
        check("err_sticky", {31'd0, err}, 32'd1);

        // 3: empty transfer keeps err as it was
        exp_done_q.push_back(1'b1);
        send(hdr(7, 0), 0);
        idle(3);

        // 4: gappy stream to boxes 0..3
        for (int i = 0; i < 4; i++) expect_strobe(i, 32'h4000_0000 + 32'(i));
        exp_done_q.push_back(1'b0);
        send(hdr(0, 4), int'($urandom_range(0, 3)));
        for (int i = 0; i < 4; i++) send(32'h4000_0000 + 32'(i), int'($urandom_range(0, 3)));
        idle(3);

        // 5: reset after two of four payload words
        expect_strobe(0, 32'h5000_0000);
        expect_strobe(1, 32'h5000_0001);
        send(hdr(0, 4), 0);
        send(32'h5000_0000, 0);
        send(32'h5000_0001, 0);
        cfg_in_valid = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_en", 32'(sb_config_en), 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        last_data = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        expect_strobe(5, 32'h5555_5555);
        exp_done_q.push_back(1'b0);
        send(hdr(5, 1), 0);
        send(32'h5555_5555, 0);
        idle(3);

        // 6: full sweep
        for (int i = 0; i < N; i++) begin
            w = $urandom;
            sent[i] = w;
            expect_strobe(i, w);
        end
        exp_done_q.push_back(1'b0);
        send(hdr(0, N), 0);
        for (int i = 0; i < N; i++) send(sent[i], 0);
        idle(4);
        for (int i = 0; i < N; i++) check($sformatf("box_model[%0d]", i), box_model[i], sent[i]);
        check("sweep_err", {31'd0, err}, 32'd0);

        check("strobes_left", 32'(exp_q.size()), 32'd0);
        check("dones_left", 32'(exp_done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
